// File: rtl/press_counter.sv
// Button-event capture: each press of key_i[0] latches the switches and bumps
// an 8-bit count shown as two hex digits; key_i[1] held low clears both.
module press_counter (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic [9:0] sw_i,
    input  logic [1:0] key_i,
    output logic [9:0] ledr_o,
    output logic [6:0] hex0_o,
    output logic [6:0] hex1_o
);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] hist_q, hist_d;
    logic [9:0] data_q, data_d;
    logic [7:0] cnt_q, cnt_d;
    logic       press_evt;
    logic       clear_act;

    // Active-low segment decode, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        sync1_d   = key_i;
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        press_evt = hist_q[0] & ~sync2_q[0];
        clear_act = ~sync2_q[1];
        data_d    = data_q;
        cnt_d     = cnt_q;
        // Clear wins over a simultaneous press, which is simply dropped
        if (clear_act) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (press_evt) begin
            data_d = sw_i;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            hist_q  <= 2'b11;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [6:0] seg_out [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
        assign seg_out[gi] = seg7(cnt_q[gi*4 +: 4]);
    end

    assign ledr_o = data_q;
    assign hex0_o = seg_out[0];
    assign hex1_o = seg_out[1];

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter: reset, press latency, wrap, clear,
// idle switch changes and reset while a key is held.
module tb_press_counter;

    logic       clk100_i = 1'b0;
    logic       rst_i    = 1'b1;
    logic [9:0] sw_i     = '0;
    logic [1:0] key_i    = 2'b11;
    logic [9:0] ledr_o;
    logic [6:0] hex0_o;
    logic [6:0] hex1_o;

    int n_checks = 0;
    int n_pass   = 0;

    press_counter dut (
        .clk100_i(clk100_i),
        .rst_i   (rst_i),
        .sw_i    (sw_i),
        .key_i   (key_i),
        .ledr_o  (ledr_o),
        .hex0_o  (hex0_o),
        .hex1_o  (hex1_o)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%h exp=%h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving us 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk100_i);
        #1;
    endtask

    // One press: key_i[0] low for exactly one sampling edge, then released
    task automatic press(input logic [9:0] sw);
        sw_i     = sw;
        key_i[0] = 1'b0;
        tick(1);
        key_i[0] = 1'b1;
        tick(3);
    endtask

    initial begin
        // Reset
        tick(1);
        check("rst_ledr", 16'(ledr_o), 16'h000);
        check("rst_hex0", 16'(hex0_o), 16'h40);
        check("rst_hex1", 16'(hex1_o), 16'h40);
        rst_i = 1'b0;
        tick(1);

        // Single press held 4 cycles
        sw_i     = 10'h2A5;
        key_i[0] = 1'b0;
        tick(2);
        check("pre_ledr", 16'(ledr_o), 16'h000);
        check("pre_hex0", 16'(hex0_o), 16'h40);
        tick(1);
        check("press_ledr", 16'(ledr_o), 16'h2A5);
        check("press_hex0", 16'(hex0_o), 16'h79);
        check("press_hex1", 16'(hex1_o), 16'h40);
        tick(1);
        key_i[0] = 1'b1;
        sw_i     = 10'h155;
        tick(4);
        check("hold_hex0", 16'(hex0_o), 16'h79);
        check("hold_ledr", 16'(ledr_o), 16'h2A5);

        // 25 more presses -> 26 = 8'h1A
        for (int i = 2; i <= 26; i++) press(10'(i));
        check("c26_hex1", 16'(hex1_o), 16'h79);
        check("c26_hex0", 16'(hex0_o), 16'h08);
        check("c26_ledr", 16'(ledr_o), 16'h01A);
        // up to 256 -> wraps to zero
        for (int i = 27; i <= 256; i++) press(10'(i + 10'h100));
        check("wrap_hex0", 16'(hex0_o), 16'h40);
        check("wrap_hex1", 16'(hex1_o), 16'h40);
        check("wrap_ledr", 16'(ledr_o), 16'h200);
        press(10'h3C3);
        check("c1_hex0", 16'(hex0_o), 16'h79);

        // Clear with an overlapping press
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) press(10'h0F0 + 10'(i));
        check("c5_hex0", 16'(hex0_o), 16'h12);
        key_i = 2'b00;
        tick(2);
        check("clr_pre_hex0", 16'(hex0_o), 16'h12);
        key_i = 2'b11;
        tick(1);
        check("clr_hex0", 16'(hex0_o), 16'h40);
        check("clr_ledr", 16'(ledr_o), 16'h000);
        tick(4);
        check("clr_after", 16'(hex0_o), 16'h40);
        press(10'h0AB);
        check("postclr_hex0", 16'(hex0_o), 16'h79);
        check("postclr_ledr", 16'(ledr_o), 16'h0AB);

        // Switch changes with keys released
        for (int i = 0; i < 5; i++) begin
            sw_i = 10'($urandom);
            tick(4);
            check("idle_ledr", 16'(ledr_o), 16'h0AB);
            check("idle_hex0", 16'(hex0_o), 16'h79);
        end

        // Reset while key_i[0] held low
        sw_i     = 10'h1E1;
        key_i[0] = 1'b0;
        tick(3);
        check("held_hex0", 16'(hex0_o), 16'h24);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("rsth_hex0", 16'(hex0_o), 16'h40);
        check("rsth_ledr", 16'(ledr_o), 16'h000);
        tick(2);
        check("refill_hex0", 16'(hex0_o), 16'h40);
        tick(1);
        check("repress_hex0", 16'(hex0_o), 16'h79);
        check("repress_ledr", 16'(ledr_o), 16'h1E1);
        tick(5);
        check("reheld_hex0", 16'(hex0_o), 16'h79);
        key_i[0] = 1'b1;
        tick(4);
        check("rel_hex0", 16'(hex0_o), 16'h79);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/press_counter.md
# press_counter

Button-event capture block for the board-level practicum top. Each press of `key_i[0]` latches the 10 slide switches into a data register shown on the red LEDs and increments an 8-bit press count. The count is shown in hex on two seven-segment digits. `key_i[1]` acts as a user clear. All logic runs in a single clock domain; the buttons are synchronized internally.

## Interface
One clock; reset is synchronous and active-high (`clk100_i`, `rst_i`). No parameters.

- `clk100_i` in, 1 — system clock; all state updates on its rising edge.
- `rst_i` in, 1 — synchronous, active-high reset.
- `sw_i` in, 10 — slide switches; the value to capture.
- `key_i` in, 2 — push buttons, active-low (1 = released).
  - `[0]` = capture/count.
  - `[1]` = clear.
- `ledr_o` out, 10 — captured data register.
- `hex0_o` out, 7 — low hex digit of the count. Segments are active-low, bit order {g,f,e,d,c,b,a}.
- `hex1_o` out, 7 — high hex digit of the count, same encoding.

## Operation
- Each key passes through a 2-flop synchronizer followed by a history flop.
  - Synchronizer and history flops reset to 1 (released).
- **Press event:** the synchronized `key_i[0]` was 1 on the previous cycle and is 0 now.
  - Exactly one event per press, regardless of hold time.
  - Release (0→1) has no effect.
- **On a press event:**
  - `data_q <= sw_i`, with `sw_i` sampled raw at that edge.
  - `cnt_q <= cnt_q + 1`, mod 256; 8'hFF wraps to 8'h00.
- **Clear:** while the synchronized `key_i[1]` is 0, `data_q <= 0` and `cnt_q <= 0`, every cycle it is held.
- **Priority:** `rst_i` > clear > press event.
  - A press event in a clear cycle is discarded.
- **Outputs:**
  - `ledr_o = data_q`.
  - `hex0_o = seg(cnt_q[3:0])`, `hex1_o = seg(cnt_q[7:4])`; both combinational decodes.
- **`seg()` table** (active-low, {g..a}):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30
  - 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
  - 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03
  - C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E

## Timing
- **Reset:** `rst_i` sampled high at an edge gives, after that edge:
  - `data_q = 0`, `cnt_q = 0`.
  - `ledr_o = 10'h000`, `hex0_o = hex1_o = 7'h40`.
  - All synchronizer and history flops = 1.
- **Press latency:** let E0 be the first rising edge that samples `key_i[0] = 0`.
  - The press event is asserted during the cycle after E0+1.
  - `data_q` and `cnt_q` update at E0+2, capturing `sw_i` as sampled at E0+2.
  - Outputs reflect the new values immediately after E0+2.
- **Clear latency:**
  - Assertion: first edge sampling `key_i[1] = 0` is E0; registers are zero after E0+2.
  - Release: the block stays cleared until 2 edges after the first edge sampling `key_i[1] = 1`.
- **Minimum press:** `key_i[0]` low for at least one sampling edge is detected as one press. Glitches shorter than one clock period may be missed.
- **Minimum spacing:** back-to-back presses need `key_i[0]` sampled high for at least one edge between them; each such low period counts once.
- **Reset mid-operation:** `rst_i` overrides everything at that edge. A key still held low after reset:
  - For `key_i[0]`: after the synchronizers refill, the held-low level is seen as a falling edge and counts one press.
  - For `key_i[1]`: clearing resumes.
- Inputs are asynchronous to the clock; `sw_i` is used only on the capture edge and must be stable around it.

## Test plan
- **Reset:** assert `rst_i` 1 cycle -> `ledr_o = 0`, `hex0_o = hex1_o = 7'h40`.
- **Single press:** `sw_i = 10'h2A5`, `key_i[0]` low 4 cycles, then high -> exactly 2 edges after the first low sample:
  - `ledr_o = 10'h2A5`, `hex0_o = 7'h79` (1), `hex1_o = 7'h40`.
  - No further change while held or on release.
- **Count wrap:** 26 presses -> `cnt_q = 8'h1A`, `hex1_o = 7'h79`, `hex0_o = 7'h08`. Continue to 256 presses -> `cnt_q = 0`, both digits 7'h40; `ledr_o` = last `sw_i`.
- **Clear:** after 5 presses, drive `key_i[1]` low 2 cycles -> `ledr_o = 0` and count 0 two edges after the first low sample. A press overlapping the clear is not counted.
- **Switch changes without press:** randomize `sw_i` every 4 cycles with keys released -> `ledr_o` and the count are unchanged.
- **Reset vs held key:** hold `key_i[0]` low, pulse `rst_i` -> count 0 at the reset edge, then exactly one press counted (`cnt_q = 1`) after the synchronizers refill.
